// File: rtl/wbq_pkg.sv
// Shared types and defaults for the register-file writeback queue.
package wbq_pkg;

  localparam int WBQ_DATA_W = 32;
  localparam int WBQ_ADDR_W = 5;

  localparam logic [WBQ_ADDR_W-1:0] WBQ_REG_ZERO = '0;

  // One queued long-latency result; live drops when a younger ALU write supersedes it.
  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] regIdx;
    logic [WBQ_DATA_W-1:0] data;
    logic                  live;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Per-register lookup over the queue contents: hit flag plus youngest live value.
// Value forwarding is built only when WBQ_FORWARD_EN is defined; otherwise data is tied to 0.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  wbq_entry_t              entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] tail,
  input  logic [ADDR_W-1:0]       chkReg,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef WBQ_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Walk from the youngest slot (tail-1) back toward the head; first live match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PTR_W'(k + 1);
      if (!hit && chkReg != WBQ_REG_ZERO && entries[idx].live &&
          entries[idx].regIdx == chkReg) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
`else
  logic unusedBits;

  // Without forwarding only presence matters, so age order is irrelevant.
  always_comb begin
    hit        = 1'b0;
    unusedBits = ^tail;
    for (int k = 0; k < DEPTH; k++) begin
      hit        = hit | (entries[k].live && entries[k].regIdx == chkReg);
      unusedBits = unusedBits ^ (^entries[k].data);
    end
    hit = hit && (chkReg != WBQ_REG_ZERO);
  end

  assign data = '0;
`endif

endmodule

// File: rtl/writeback_queue.sv
// Register-file write-port arbiter: ALU writes pass through, long-latency results queue in order.
// Optional WBQ_FORWARD_EN makes the lookups return the youngest queued value.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_wr_en,
  input  logic [ADDR_W-1:0]        alu_wr_reg,
  input  logic [DATA_W-1:0]        alu_wr_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [ADDR_W-1:0]        lu_reg,
  input  logic [DATA_W-1:0]        lu_data,
  input  logic [ADDR_W-1:0]        chk_reg1,
  input  logic [ADDR_W-1:0]        chk_reg2,
  output logic                     chk_hit1,
  output logic                     chk_hit2,
  output logic [DATA_W-1:0]        chk_data1,
  output logic [DATA_W-1:0]        chk_data2,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  output logic                     regWrite,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t       entries [DEPTH];
  wbq_entry_t       headEnt;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] countQ;

  logic aluOwns;
  logic notEmpty;
  logic pop;
  logic store;
  logic hit1Raw;
  logic hit2Raw;
  logic [DATA_W-1:0] data1Raw;
  logic [DATA_W-1:0] data2Raw;

  assign headEnt  = entries[head];
  assign aluOwns  = alu_wr_en && (alu_wr_reg != WBQ_REG_ZERO);
  assign notEmpty = (countQ != '0);
  // A dead head leaves every cycle; a live head only when the ALU is not using the port.
  assign pop      = notEmpty && (!headEnt.live || !aluOwns);
  assign lu_ready = !rst && (countQ < CNT_W'(DEPTH));
  assign store    = lu_valid && lu_ready && (lu_reg != WBQ_REG_ZERO);
  assign count    = countQ;

  always_comb begin
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    if (!rst) begin
      if (aluOwns) begin
        regWrite  = 1'b1;
        writeReg  = alu_wr_reg;
        writeData = alu_wr_data;
      end else if (notEmpty && headEnt.live) begin
        regWrite  = 1'b1;
        writeReg  = headEnt.regIdx;
        writeData = headEnt.data;
      end
    end
  end

  // Later assignments win: the pop clear and the fresh enqueue override the WAW kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      countQ <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (aluOwns && entries[i].regIdx == alu_wr_reg) entries[i].live <= 1'b0;
      end
      if (pop) begin
        entries[head].live <= 1'b0;
        head               <= head + PTR_W'(1);
      end
      if (store) begin
        entries[tail] <= '{regIdx: lu_reg, data: lu_data, live: 1'b1};
        tail          <= tail + PTR_W'(1);
      end
      unique case ({store, pop})
        2'b10:   countQ <= countQ + CNT_W'(1);
        2'b01:   countQ <= countQ - CNT_W'(1);
        default: ;
      endcase
    end
  end

  wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) uMatch1 (
    .entries(entries), .tail(tail), .chkReg(chk_reg1), .hit(hit1Raw), .data(data1Raw)
  );

  wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) uMatch2 (
    .entries(entries), .tail(tail), .chkReg(chk_reg2), .hit(hit2Raw), .data(data2Raw)
  );

  assign chk_hit1  = !rst && hit1Raw;
  assign chk_hit2  = !rst && hit2Raw;
  assign chk_data1 = rst ? '0 : data1Raw;
  assign chk_data2 = rst ? '0 : data2Raw;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table plus random traffic against a queue model.
module tb_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              alu_wr_en;
  logic [ADDR_W-1:0] alu_wr_reg;
  logic [DATA_W-1:0] alu_wr_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_reg;
  logic [DATA_W-1:0] lu_data;
  logic [ADDR_W-1:0] chk_reg1, chk_reg2;
  logic              chk_hit1, chk_hit2;
  logic [DATA_W-1:0] chk_data1, chk_data2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic [2:0]        count;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_en(alu_wr_en), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .chk_data1(chk_data1), .chk_data2(chk_data2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .count(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: in-order list of pending writes ----------------
  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    bit                live;
  } ment_t;
  ment_t mq[$];

  task automatic lookup(input logic [ADDR_W-1:0] r, output bit hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 0) begin
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].r == r) begin
          hit = 1'b1;
          d   = mq[i].d;
        end
      end
    end
    if (!FWD) d = '0;
  endtask

  task automatic checkModel(input string tag);
    bit                aluOwn, eRw, h1, h2;
    logic [ADDR_W-1:0] eWr;
    logic [DATA_W-1:0] eWd, d1, d2;
    aluOwn = alu_wr_en && alu_wr_reg != 0;
    eRw = 1'b0; eWr = '0; eWd = '0;
    if (aluOwn) begin
      eRw = 1'b1; eWr = alu_wr_reg; eWd = alu_wr_data;
    end else if (mq.size() > 0 && mq[0].live) begin
      eRw = 1'b1; eWr = mq[0].r; eWd = mq[0].d;
    end
    lookup(chk_reg1, h1, d1);
    lookup(chk_reg2, h2, d2);
    if (rst) begin
      eRw = 1'b0; eWr = '0; eWd = '0; h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    end
    chk({tag, ".ready"},    32'(lu_ready),  32'(!rst && mq.size() < DEPTH));
    chk({tag, ".regWrite"}, 32'(regWrite),  32'(eRw));
    chk({tag, ".writeReg"}, 32'(writeReg),  32'(eWr));
    chk({tag, ".writeData"}, writeData,     eWd);
    chk({tag, ".hit1"},     32'(chk_hit1),  32'(h1));
    chk({tag, ".hit2"},     32'(chk_hit2),  32'(h2));
    chk({tag, ".data1"},    chk_data1,      d1);
    chk({tag, ".data2"},    chk_data2,      d2);
    if (!rst) chk({tag, ".count"}, 32'(count), 32'(mq.size()));
  endtask

  task automatic modelStep();
    bit aluOwn, pop, accept;
    if (rst) begin
      mq.delete();
      return;
    end
    aluOwn = alu_wr_en && alu_wr_reg != 0;
    pop    = mq.size() > 0 && (!mq[0].live || !aluOwn);
    accept = lu_valid && mq.size() < DEPTH && lu_reg != 0;
    if (aluOwn) foreach (mq[i]) if (mq[i].r == alu_wr_reg) mq[i].live = 1'b0;
    if (pop) void'(mq.pop_front());
    if (accept) mq.push_back('{r: lu_reg, d: lu_data, live: 1'b1});
  endtask

  task automatic drive(input bit r, input bit ae, input logic [ADDR_W-1:0] ar,
                       input logic [DATA_W-1:0] ad, input bit lv, input logic [ADDR_W-1:0] lr,
                       input logic [DATA_W-1:0] ld, input logic [ADDR_W-1:0] c1,
                       input logic [ADDR_W-1:0] c2);
    rst = r; alu_wr_en = ae; alu_wr_reg = ar; alu_wr_data = ad;
    lu_valid = lv; lu_reg = lr; lu_data = ld; chk_reg1 = c1; chk_reg2 = c2;
  endtask

  task automatic modelCycle(input string tag);
    @(negedge clk);
    checkModel(tag);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // ---------------- directed vectors: expected values at mid-cycle ----------------
  typedef struct {
    bit                rst, aluEn, luValid;
    logic [ADDR_W-1:0] aluReg, luReg, c1, c2;
    logic [DATA_W-1:0] aluData, luData;
    bit                eReady, eRw, eHit1, eHit2;
    logic [ADDR_W-1:0] eWr;
    logic [DATA_W-1:0] eWd, eFwd1, eFwd2;
    int                eCnt;
  } vec_t;
  vec_t vt[$];

  function automatic void addV(bit r, bit ae, logic [ADDR_W-1:0] ar, logic [DATA_W-1:0] ad,
                               bit lv, logic [ADDR_W-1:0] lr, logic [DATA_W-1:0] ld,
                               logic [ADDR_W-1:0] c1, logic [ADDR_W-1:0] c2,
                               bit eRdy, bit eRw, logic [ADDR_W-1:0] eWr, logic [DATA_W-1:0] eWd,
                               bit eH1, logic [DATA_W-1:0] eF1, bit eH2, logic [DATA_W-1:0] eF2,
                               int eCnt);
    vec_t x;
    x.rst = r; x.aluEn = ae; x.aluReg = ar; x.aluData = ad;
    x.luValid = lv; x.luReg = lr; x.luData = ld; x.c1 = c1; x.c2 = c2;
    x.eReady = eRdy; x.eRw = eRw; x.eWr = eWr; x.eWd = eWd;
    x.eHit1 = eH1; x.eFwd1 = eF1; x.eHit2 = eH2; x.eFwd2 = eF2; x.eCnt = eCnt;
    vt.push_back(x);
  endfunction

  initial begin
    // single enqueue drains the next cycle
    addV(0,0,0,0, 1,3,32'hAAAA_0001, 3,0,  1,0,0,0,                0,0,0,0, 0);
    addV(0,0,0,0, 0,0,0,             3,0,  1,1,3,32'hAAAA_0001,    1,32'hAAAA_0001,0,0, 1);
    addV(0,0,0,0, 0,0,0,             3,0,  1,0,0,0,                0,0,0,0, 0);
    // fill while the ALU owns the port, then drain in order
    addV(0,1,7,32'h77, 1,1,32'h101, 1,0,   1,1,7,32'h77, 0,0,0,0, 0);
    addV(0,1,7,32'h77, 1,2,32'h102, 1,0,   1,1,7,32'h77, 1,32'h101,0,0, 1);
    addV(0,1,7,32'h77, 1,4,32'h104, 1,2,   1,1,7,32'h77, 1,32'h101,1,32'h102, 2);
    addV(0,1,7,32'h77, 1,6,32'h106, 1,4,   1,1,7,32'h77, 1,32'h101,1,32'h104, 3);
    addV(0,1,7,32'h77, 1,8,32'h108, 1,6,   0,1,7,32'h77, 1,32'h101,1,32'h106, 4);
    addV(0,0,0,0,      1,8,32'h108, 1,6,   0,1,1,32'h101, 1,32'h101,1,32'h106, 4);
    addV(0,0,0,0,      0,0,0,       1,2,   1,1,2,32'h102, 0,0,1,32'h102, 3);
    addV(0,0,0,0,      0,0,0,       4,8,   1,1,4,32'h104, 1,32'h104,0,0, 2);
    addV(0,0,0,0,      0,0,0,       6,0,   1,1,6,32'h106, 1,32'h106,0,0, 1);
    addV(0,0,0,0,      0,0,0,       6,0,   1,0,0,0, 0,0,0,0, 0);
    // WAW kill: queued reg5 superseded by ALU, pops silently
    addV(0,0,0,0,      1,5,32'h11,  5,0,   1,0,0,0, 0,0,0,0, 0);
    addV(0,1,5,32'h22, 0,0,0,       5,0,   1,1,5,32'h22, 1,32'h11,0,0, 1);
    addV(0,0,0,0,      0,0,0,       5,0,   1,0,0,0, 0,0,0,0, 1);
    addV(0,0,0,0,      0,0,0,       5,0,   1,0,0,0, 0,0,0,0, 0);
    // two writes to reg9: youngest value forwarded
    addV(0,1,30,32'h30, 1,9,32'h10, 9,0,   1,1,30,32'h30, 0,0,0,0, 0);
    addV(0,1,30,32'h30, 1,9,32'h20, 9,0,   1,1,30,32'h30, 1,32'h10,0,0, 1);
    addV(0,1,30,32'h30, 0,0,0,      9,9,   1,1,30,32'h30, 1,32'h20,1,32'h20, 2);
    addV(0,0,0,0,       0,0,0,      9,0,   1,1,9,32'h10, 1,32'h20,0,0, 2);
    addV(0,0,0,0,       0,0,0,      9,0,   1,1,9,32'h20, 1,32'h20,0,0, 1);
    addV(0,0,0,0,       0,0,0,      9,0,   1,0,0,0, 0,0,0,0, 0);
    // register zero on both sides
    addV(0,1,0,32'h55,  1,0,32'h99, 0,0,   1,0,0,0, 0,0,0,0, 0);
    addV(0,0,0,0,       0,0,0,      0,0,   1,0,0,0, 0,0,0,0, 0);
    addV(0,0,0,0,       1,10,32'hA0, 0,0,  1,0,0,0, 0,0,0,0, 0);
    addV(0,1,0,32'h5,   0,0,0,      10,0,  1,1,10,32'hA0, 1,32'hA0,0,0, 1);
    addV(0,0,0,0,       0,0,0,      10,0,  1,0,0,0, 0,0,0,0, 0);
    // reset with three entries queued
    addV(0,1,30,32'h30, 1,11,32'hB1, 0,0,   1,1,30,32'h30, 0,0,0,0, 0);
    addV(0,1,30,32'h30, 1,12,32'hB2, 11,0,  1,1,30,32'h30, 1,32'hB1,0,0, 1);
    addV(0,1,30,32'h30, 1,13,32'hB3, 11,12, 1,1,30,32'h30, 1,32'hB1,1,32'hB2, 2);
    addV(1,1,30,32'h30, 1,14,32'hB4, 11,13, 0,0,0,0, 0,0,0,0, 3);
    addV(0,0,0,0,       0,0,0,       11,13, 1,0,0,0, 0,0,0,0, 0);
    // dead head pops silently during an ALU cycle
    addV(0,0,0,0,       1,6,32'h61, 6,0,   1,0,0,0, 0,0,0,0, 0);
    addV(0,1,6,32'h62,  0,0,0,      6,0,   1,1,6,32'h62, 1,32'h61,0,0, 1);
    addV(0,1,7,32'h70,  0,0,0,      6,0,   1,1,7,32'h70, 0,0,0,0, 1);
    addV(0,0,0,0,       0,0,0,      6,0,   1,0,0,0, 0,0,0,0, 0);

    drive(1,0,0,0, 0,0,0, 0,0);
    modelCycle("reset0");
    modelCycle("reset1");
    drive(0,0,0,0, 0,0,0, 0,0);
    modelCycle("postReset");

    for (int i = 0; i < vt.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vt[i].rst, vt[i].aluEn, vt[i].aluReg, vt[i].aluData,
            vt[i].luValid, vt[i].luReg, vt[i].luData, vt[i].c1, vt[i].c2);
      @(negedge clk);
      chk({tag, ".ready"},     32'(lu_ready),  32'(vt[i].eReady));
      chk({tag, ".regWrite"},  32'(regWrite),  32'(vt[i].eRw));
      chk({tag, ".writeReg"},  32'(writeReg),  32'(vt[i].eWr));
      chk({tag, ".writeData"}, writeData,      vt[i].eWd);
      chk({tag, ".hit1"},      32'(chk_hit1),  32'(vt[i].eHit1));
      chk({tag, ".hit2"},      32'(chk_hit2),  32'(vt[i].eHit2));
      chk({tag, ".data1"},     chk_data1,      FWD ? vt[i].eFwd1 : 32'h0);
      chk({tag, ".data2"},     chk_data2,      FWD ? vt[i].eFwd2 : 32'h0);
      chk({tag, ".count"},     32'(count),     32'(vt[i].eCnt));
      @(posedge clk);
      #1;
    end

    // random traffic on a small register set so collisions are frequent
    for (int i = 0; i < 800; i++) begin
      drive((i == 0) || ($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      modelCycle($sformatf("r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-port arbiter and buffer placed directly upstream of the register file's single write port (`writeReg`/`writeData`/`regWrite`). ALU results write through in the same cycle with absolute priority; results from long-latency units (load, multiply/divide) enter a small in-order FIFO and drain on cycles the ALU leaves the port idle. Per-register lookups let the issue stage detect pending writes and, optionally, forward queued values.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2
- `DATA_W`, 32: result width
- `ADDR_W`, 5: register index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_wr_en`  in  1  ALU result valid this cycle
- `alu_wr_reg`  in  ADDR_W  ALU destination
- `alu_wr_data`  in  DATA_W  ALU result
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  queue accepts offer
- `lu_reg`  in  ADDR_W  long-latency destination
- `lu_data`  in  DATA_W  long-latency result
- `chk_reg1`, `chk_reg2`  in  ADDR_W  issue-stage source lookups
- `chk_hit1`, `chk_hit2`  out  1  live queued write pending for that register
- `chk_data1`, `chk_data2`  out  DATA_W  youngest matching queued value
- `writeReg`  out  ADDR_W  to register file
- `writeData`  out  DATA_W  to register file
- `regWrite`  out  1  to register file
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Entry = {reg, data, live}. FIFO uses head/tail pointers that wrap modulo DEPTH, plus a registered count.
- Enqueue on `lu_valid && lu_ready`. `lu_ready = !rst && count < DEPTH`. A full queue never accepts, even when it is draining in the same cycle.
- `lu_reg == 0`: handshake completes, nothing is stored.
- Port mux (combinational):
  - `alu_wr_en && alu_wr_reg != 0`: ALU drives the port.
  - Otherwise, if the head is live, the head drives the port and pops.
  - Otherwise `regWrite = 0`.
- `alu_wr_en` with `alu_wr_reg == 0` leaves the port free for the queue.
- Dead head: pops silently in any cycle, including ALU cycles, one pop per cycle maximum, with `regWrite` unaffected.
- WAW kill: an ALU write to register X clears `live` on every queued entry with reg X, since the ALU value is architecturally youngest. An entry enqueued in the same cycle to X is not killed.
- Lookup: `chk_hitN` = any live entry with reg == `chk_regN` != 0. The head that is draining this cycle still counts, because the register file has not yet absorbed it.
- When both enqueue and pop occur in one cycle, count is unchanged.
- Unused `writeReg`/`writeData` outputs are 0 when `regWrite = 0`.

## Timing
- ALU write latency: 0 cycles (combinational pass-through).
- Queue latency: an enqueue at edge N can drain during cycle N+1 at the earliest.
- Throughput: one enqueue and one pop per cycle.
- Lookups are combinational on the registered queue state. They exclude an enqueue happening in the current cycle.
- Reset:
  - count = 0, pointers = 0, all `live` = 0.
  - `lu_ready` = 0 while `rst` is high.
  - `regWrite` = 0, `writeReg` = 0, `writeData` = 0, `chk_hit*` = 0, `chk_data*` = 0.
- Reset mid-drain discards all queued entries. No partial write reaches the register file, because `regWrite` is forced to 0 while `rst` is high.

## Configuration
- `WBQ_FORWARD_EN` defined:
  - `chk_dataN` returns the youngest live match.
  - The issue stage may bypass instead of stalling.
- Not defined:
  - `chk_dataN` is tied to 0 and no match priority logic is built.
  - `chk_hitN` is still produced; the issue stage must stall on a hit.

## Structure
- Package `wbq_pkg` holds:
  - the `wbq_entry_t` struct {reg, data, live}
  - the `DATA_W`/`ADDR_W` defaults
  - the `WBQ_REG_ZERO` constant
- Sub-module `wbq_match`: scans DEPTH entries for one lookup register and returns hit plus youngest data, ordering entries from tail-1 back to head. It is instantiated twice.

## Test plan
- Enqueue reg 3 = 0xAAAA_0001 on an idle ALU → next cycle `regWrite` = 1, `writeReg` = 3, `writeData` = 0xAAAA_0001, count 1→0.
- Fill 4 entries while `alu_wr_en` is held high to reg 7 → `lu_ready` = 0 at count 4. Drop `alu_wr_en` → 4 consecutive drains in FIFO order, and `lu_ready` returns to 1 after the first pop.
- Queue reg 5 = 0x11, then ALU writes reg 5 = 0x22 → the queued entry pops without `regWrite`, and `chk_hit` for 5 goes to 0.
- Queue reg 9 = 0x10, then reg 9 = 0x20 with `WBQ_FORWARD_EN` defined → `chk_hit1` = 1 and `chk_data1` = 0x20. Without the macro, `chk_data1` = 0.
- Offer `lu_reg` = 0 and `alu_wr_reg` = 0 → `lu_ready` handshake completes, count stays 0, `regWrite` stays 0.
- Assert `rst` with 3 entries queued → the next cycle shows count 0, `regWrite` 0 and no hits, and `lu_ready` = 1 after `rst` deasserts.
